// File: rtl/vedic_mul_seq.sv
// vedic_mul_seq: multi-cycle signed/unsigned multiplier producing a full
// 2*WIDTH product. One HALF x HALF Vedic (vertically-and-crosswise) core
// is reused over four partial-product steps on operand magnitudes; the
// sign is re-applied in a final FIX cycle. Valid/ready on both sides.
module vedic_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int HALF  = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int COL_W = $clog2(HALF + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic              negate;
    logic [1:0]        step;
    logic [PW-1:0]     acc;

    logic              accept;
    logic              sign_a;
    logic              sign_b;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [HALF-1:0]   mul_a;
    logic [HALF-1:0]   mul_b;
    logic [3*HALF-1:0] b_pad;
    logic [3*HALF-1:0] b_sh;
    logic [HALF-1:0]   a_sh;
    logic [COL_W-1:0]  col;
    logic [WIDTH-1:0]  pp_prod;
    logic [PW-1:0]     pp_ext;
    logic [PW-1:0]     addend;

    assign accept = in_valid & in_ready;

    // Operand sign extraction and magnitude; the most-negative value maps to
    // 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    assign sign_a = src_a[WIDTH-1] & ((op == 2'b01) | (op == 2'b10));
    assign sign_b = src_b[WIDTH-1] & (op == 2'b01);
    assign mag_a  = sign_a ? -src_a : src_a;
    assign mag_b  = sign_b ? -src_b : src_b;

    // Step picks the operand halves: bit 1 selects A high, bit 0 selects B high.
    assign mul_a = step[1] ? abs_a[WIDTH-1:HALF] : abs_a[HALF-1:0];
    assign mul_b = step[0] ? abs_b[WIDTH-1:HALF] : abs_b[HALF-1:0];

    // B padded with HALF zeros on each side so column k, row i always reads
    // bit (k - i + HALF) in range, with zeros outside the diagonal.
    assign b_pad = {{HALF{1'b0}}, mul_b, {HALF{1'b0}}};

    // Vertically-and-crosswise core: each column sums its crosswise bit
    // products, columns are then weighted by position and added.
    always_comb begin
        // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
        pp_prod = '0;
        col     = '0;
        a_sh    = '0;
        b_sh    = '0;
        for (int k = 0; k < 2 * HALF - 1; k++) begin
            col = '0;
            for (int i = 0; i < HALF; i++) begin
                a_sh = mul_a >> i;
                b_sh = b_pad >> (k - i + HALF);
                col  = col + COL_W'(a_sh[0] & b_sh[0]);
            end
            pp_prod = pp_prod + (WIDTH'(col) << k);
        end
    end

    // Align the partial product to its weight for the current step.
    always_comb begin
        pp_ext = {{WIDTH{1'b0}}, pp_prod};
        addend = pp_ext;
        case (step)
            2'd0:    addend = pp_ext;
            2'd1:    addend = pp_ext << HALF;
            2'd2:    addend = pp_ext << HALF;
            default: addend = pp_ext << WIDTH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (step == 2'd3) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands, accumulate partial products, apply sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_a     <= '0;
            abs_b     <= '0;
            negate    <= 1'b0;
            step      <= 2'd0;
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        abs_a  <= mag_a;
                        abs_b  <= mag_b;
                        negate <= sign_a ^ sign_b;
                        acc    <= '0;
                        step   <= 2'd0;
                    end
                end
                S_MUL: begin
                    acc  <= acc + addend;
                    step <= step + 2'd1;
                end
                S_FIX: begin
                    result    <= negate ? -acc : acc;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Testbench for vedic_mul_seq: directed 8-bit vectors, backpressure and
// mid-operation reset sequences, then a 64-bit random stream with a model.
module tb_vedic_mul_seq;

    localparam int N_RAND = 1000;

    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;

    logic         in_valid64, in_ready64, out_valid64, out_ready64, busy64;
    logic [1:0]   op64;
    logic [63:0]  a64, b64;
    logic [127:0] result64;

    int errors = 0;
    int checks = 0;

    vedic_mul_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .src_a(a8), .src_b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .busy(busy8)
    );

    vedic_mul_seq #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid64), .in_ready(in_ready64), .op(op64),
        .src_a(a64), .src_b(b64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    logic [127:0] exp_q[$];
    int accepted;
    int received;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ref_mul(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ae;
        logic [127:0] be;
        ae = (o == 2'b01 || o == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
        be = (o == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        return ae * be;
    endfunction

    // One full 8-bit transaction: accept, check latency and result, drain.
    task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string name);
        int n;
        @(negedge clk);
        check({name, " in_ready"}, in_ready8, 1'b1);
        in_valid8 = 1'b1;
        op8 = o;
        a8 = a;
        b8 = b;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        op8 = ~o;
        a8 = ~a;
        b8 = ~b;
        n = 0;
        while (!out_valid8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " latency"}, n, 5);
        check({name, " result"}, result8, exp);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        check({name, " out_valid drop"}, out_valid8, 1'b0);
    endtask

    initial begin
        int n;
        logic saw;

        vecs[0] = '{2'b00, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{2'b01, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{2'b01, 8'hFF, 8'h01, 16'hFFFF};
        vecs[3] = '{2'b01, 8'h7F, 8'h80, 16'hC080};
        vecs[4] = '{2'b10, 8'hFF, 8'hFF, 16'hFF01};
        vecs[5] = '{2'b11, 8'hFF, 8'hFF, 16'hFE01};
        vecs[6] = '{2'b00, 8'h00, 8'hFF, 16'h0000};
        vecs[7] = '{2'b01, 8'h80, 8'hFF, 16'h0080};
        vecs[8] = '{2'b10, 8'h80, 8'h80, 16'hC000};
        vecs[9] = '{2'b00, 8'h12, 8'h34, 16'h03A8};

        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready8, 1'b1);
        check("reset out_valid", out_valid8, 1'b0);
        check("reset busy", busy8, 1'b0);
        check("reset result", result8, 16'h0);
        check("reset in_ready64", in_ready64, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        foreach (vecs[i]) begin
            run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: hold out_ready low in DONE while in_valid/src_a toggle.
        @(negedge clk);
        in_valid8 = 1'b1; op8 = 2'b00; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk);
        #1;
        n = 0;
        while (!out_valid8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp latency", n, 5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid8 = ~in_valid8;
            a8 = 8'(c * 37 + 5);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out_valid", c), out_valid8, 1'b1);
            check($sformatf("bp%0d result", c), result8, 16'h03A8);
            check($sformatf("bp%0d in_ready", c), in_ready8, 1'b0);
            check($sformatf("bp%0d busy", c), busy8, 1'b1);
        end
        @(negedge clk);
        out_ready8 = 1'b1; in_valid8 = 1'b1; op8 = 2'b00; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk);
        #1;
        check("bp release out_valid", out_valid8, 1'b0);
        check("bp release in_ready", in_ready8, 1'b1);
        check("bp release busy", busy8, 1'b0);
        @(negedge clk);
        out_ready8 = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        check("bp next accepted", busy8, 1'b1);
        n = 0;
        while (!out_valid8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp next latency", n, 5);
        check("bp next result", result8, 16'h000F);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;

        // Reset asserted during MUL step 2 discards the operation.
        @(negedge clk);
        in_valid8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid8, 1'b0);
        check("midrst result", result8, 16'h0);
        check("midrst busy", busy8, 1'b0);
        check("midrst in_ready", in_ready8, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            saw = saw | out_valid8;
        end
        check("midrst no pulse", saw, 1'b0);
        run8(2'b00, 8'd3, 8'd5, 16'h000F, "post-reset");

        // 64-bit random stream against the reference model.
        accepted = 0;
        received = 0;
        fork
            begin : driver
                logic rdy;
                int w;
                @(negedge clk);
                for (int t = 0; t < N_RAND; t++) begin
                    in_valid64 = 1'b1;
                    op64 = 2'($urandom_range(0, 3));
                    a64 = {$urandom, $urandom};
                    b64 = {$urandom, $urandom};
                    if (t % 7 == 0) a64 = 64'h8000_0000_0000_0000;
                    if (t % 11 == 0) b64 = '0;
                    w = 0;
                    rdy = in_ready64;
                    while (!rdy && w < 200) begin
                        @(negedge clk);
                        rdy = in_ready64;
                        w++;
                    end
                    if (!rdy) begin
                        check("rand accept wait", in_ready64, 1'b1);
                        break;
                    end
                    @(posedge clk);
                    exp_q.push_back(ref_mul(op64, a64, b64));
                    accepted++;
                    @(negedge clk);
                    in_valid64 = 1'b0;
                    op64 = ~op64;
                    a64 = ~a64;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                in_valid64 = 1'b0;
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while (received < N_RAND && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready64 = ($urandom_range(0, 2) != 0);
                    if (out_valid64 && out_ready64) begin
                        if (exp_q.size() == 0) begin
                            check("rand unexpected output", out_valid64, 1'b0);
                        end else begin
                            check($sformatf("rand result %0d", received), result64, exp_q.pop_front());
                        end
                        received++;
                    end
                end
                out_ready64 = 1'b0;
            end
        join
        check("rand accepted count", accepted, N_RAND);
        check("rand received count", received, N_RAND);
        check("rand leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
